// File: rtl/reg8080_pkg.sv
// ============================================================================
// reg8080_pkg : 8080 register indices, pair codes and write-mask helpers
// Revision    : 1.0
// ============================================================================
`default_nettype none

package reg8080_pkg;

  localparam logic [2:0] REG_B = 3'd0;
  localparam logic [2:0] REG_C = 3'd1;
  localparam logic [2:0] REG_D = 3'd2;
  localparam logic [2:0] REG_E = 3'd3;
  localparam logic [2:0] REG_H = 3'd4;
  localparam logic [2:0] REG_L = 3'd5;
  localparam logic [2:0] REG_F = 3'd6;
  localparam logic [2:0] REG_A = 3'd7;

  localparam logic [1:0] PAIR_BC  = 2'd0;
  localparam logic [1:0] PAIR_DE  = 2'd1;
  localparam logic [1:0] PAIR_HL  = 2'd2;
  localparam logic [1:0] PAIR_PSW = 2'd3;

  typedef struct packed {
    logic        pair;
    logic [2:0]  addr;
    logic [15:0] data;
  } wb_entry_t;

  // PSW breaks the 2p/2p+1 pattern: A is the high half, F the low half.
  function automatic logic [2:0] pair_hi(input logic [1:0] p);
    return (p == PAIR_PSW) ? REG_A : {p, 1'b0};
  endfunction

  function automatic logic [2:0] pair_lo(input logic [1:0] p);
    return (p == PAIR_PSW) ? REG_F : {p, 1'b1};
  endfunction

  function automatic logic [7:0] wb_mask(input logic pair, input logic [2:0] addr);
    if (pair)
      return (8'd1 << pair_hi(addr[1:0])) | (8'd1 << pair_lo(addr[1:0]));
    else
      return 8'd1 << addr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// wb_fifo : circular write-back queue, one push and up to two pops per cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_fifo
  import reg8080_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  wb_entry_t                  push_entry,
  input  logic [1:0]                 pop,
  output wb_entry_t                  head,
  output wb_entry_t                  next,
  output logic                       head_valid,
  output logic                       next_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 queued_mask
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t         mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [PW:0]       cnt;

  assign count      = cnt;
  assign head_valid = (cnt != '0);
  assign next_valid = (cnt > (PW+1)'(1));
  assign head       = mem[rd_ptr];
  assign next       = mem[rd_ptr + PW'(1)];

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [PW-1:0] off;
    queued_mask = 8'd0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if ({1'b0, off} < cnt)
        queued_mask = queued_mask | wb_mask(mem[i].pair, mem[i].addr);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset && !clear)
      mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr + PW'(pop);
      cnt    <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_writeback.sv
// ============================================================================
// reg_writeback : retire queue feeding the two 8080 register-file write ports
// Revision      : 1.0
// ============================================================================
`default_nettype none

module reg_writeback
  import reg8080_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_pair,
  input  logic [2:0]                in_addr,
  input  logic [15:0]               in_data,
  input  logic                      flush,
  output logic                      wen0,
  output logic [2:0]                waddr0,
  output logic [7:0]                wdata0,
  output logic                      wen1,
  output logic [2:0]                waddr1,
  output logic [7:0]                wdata1,
  output logic [7:0]                pending,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t  head;
  wb_entry_t  next;
  wb_entry_t  push_entry;
  logic       head_valid;
  logic       next_valid;
  logic       push;
  logic [1:0] pop;
  logic       dual;
  logic [7:0] queued_mask;

  assign in_ready   = (count < CW'(DEPTH));
  assign push       = in_valid && in_ready && !flush;
  assign push_entry = '{pair: in_pair, addr: in_addr, data: in_data};

  // Two 8-bit writes retire together only when both head slots hold 8-bit entries.
  assign dual = head_valid && next_valid && !head.pair && !next.pair;

  always_comb begin
    pop = 2'd0;
    if (head_valid && !flush)
      pop = dual ? 2'd2 : 2'd1;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .clear       (flush),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head        (head),
    .next        (next),
    .head_valid  (head_valid),
    .next_valid  (next_valid),
    .count       (count),
    .queued_mask (queued_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wen0   <= 1'b0;
      waddr0 <= 3'd0;
      wdata0 <= 8'd0;
      wen1   <= 1'b0;
      waddr1 <= 3'd0;
      wdata1 <= 8'd0;
    end else if (flush || !head_valid) begin
      wen0 <= 1'b0;
      wen1 <= 1'b0;
    end else if (head.pair) begin
      wen0   <= 1'b1;
      waddr0 <= pair_hi(head.addr[1:0]);
      wdata0 <= head.data[15:8];
      wen1   <= 1'b1;
      waddr1 <= pair_lo(head.addr[1:0]);
      wdata1 <= head.data[7:0];
    end else if (dual) begin
      // Same target twice: the younger write on port 1 is the one that must land.
      wen0   <= (head.addr != next.addr);
      waddr0 <= head.addr;
      wdata0 <= head.data[7:0];
      wen1   <= 1'b1;
      waddr1 <= next.addr;
      wdata1 <= next.data[7:0];
    end else begin
      wen0   <= 1'b1;
      waddr0 <= head.addr;
      wdata0 <= head.data[7:0];
      wen1   <= 1'b0;
    end
  end

  assign pending = queued_mask
                 | (wen0 ? (8'd1 << waddr0) : 8'd0)
                 | (wen1 ? (8'd1 << waddr1) : 8'd0);

endmodule

`default_nettype wire

// File: tb/tb_reg_writeback.sv
// ============================================================================
// tb_reg_writeback : directed and random stimulus against a queue-based model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_reg_writeback;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_pair, flush;
  logic [2:0]    in_addr;
  logic [15:0]   in_data;
  logic          in_ready, wen0, wen1;
  logic [2:0]    waddr0, waddr1;
  logic [7:0]    wdata0, wdata1, pending;
  logic [CW-1:0] count;

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pair(in_pair), .in_addr(in_addr), .in_data(in_data), .flush(flush),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .pending(pending), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pair;
    int addr;
    int data;
  } ent_t;

  ent_t mq[$];
  int   m_wen0, m_addr0, m_data0, m_wen1, m_addr1, m_data1;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int hi_of(int p);
    return (p == 3) ? 7 : 2 * p;
  endfunction

  function automatic int lo_of(int p);
    return (p == 3) ? 6 : 2 * p + 1;
  endfunction

  function automatic int exp_pending();
    int m = 0;
    foreach (mq[i]) begin
      if (mq[i].pair) m |= (1 << hi_of(mq[i].addr % 4)) | (1 << lo_of(mq[i].addr % 4));
      else            m |= (1 << mq[i].addr);
    end
    if (m_wen0 != 0) m |= (1 << m_addr0);
    if (m_wen1 != 0) m |= (1 << m_addr1);
    return m;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, int exp);
    n_cmp++;
    assert (obs === 16'(exp)) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit   acc;
    ent_t e;
    int   p;
    if (reset) begin
      mq.delete();
      m_wen0 = 0; m_addr0 = 0; m_data0 = 0;
      m_wen1 = 0; m_addr1 = 0; m_data1 = 0;
    end else if (flush) begin
      mq.delete();
      m_wen0 = 0; m_wen1 = 0;
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      e   = '{in_pair, int'(in_addr), int'(in_data)};
      if (mq.size() == 0) begin
        m_wen0 = 0; m_wen1 = 0;
      end else if (mq[0].pair) begin
        p = mq[0].addr % 4;
        m_wen0 = 1; m_addr0 = hi_of(p); m_data0 = mq[0].data / 256;
        m_wen1 = 1; m_addr1 = lo_of(p); m_data1 = mq[0].data % 256;
        void'(mq.pop_front());
      end else if (mq.size() >= 2 && !mq[1].pair) begin
        m_addr0 = mq[0].addr; m_data0 = mq[0].data % 256;
        m_addr1 = mq[1].addr; m_data1 = mq[1].data % 256;
        m_wen0 = (m_addr0 != m_addr1) ? 1 : 0;
        m_wen1 = 1;
        void'(mq.pop_front());
        void'(mq.pop_front());
      end else begin
        m_wen0 = 1; m_addr0 = mq[0].addr; m_data0 = mq[0].data % 256;
        m_wen1 = 0;
        void'(mq.pop_front());
      end
      if (acc) mq.push_back(e);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 16'(in_ready), (mq.size() < DEPTH) ? 1 : 0);
    chk("count", 16'(count), mq.size());
    chk("wen0", 16'(wen0), m_wen0);
    chk("wen1", 16'(wen1), m_wen1);
    if (m_wen0 != 0) begin
      chk("waddr0", 16'(waddr0), m_addr0);
      chk("wdata0", 16'(wdata0), m_data0);
    end
    if (m_wen1 != 0) begin
      chk("waddr1", 16'(waddr1), m_addr1);
      chk("wdata1", 16'(wdata1), m_data1);
    end
    chk("pending", 16'(pending), exp_pending());
  endtask

  task automatic step(bit v, bit p, logic [2:0] a, logic [15:0] d, bit f, bit r);
    in_valid = v; in_pair = p; in_addr = a; in_data = d; flush = f; reset = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, 16'h0000, 0, 0);
  endtask

  initial begin
    in_valid = 0; in_pair = 0; in_addr = 0; in_data = 0; flush = 0; reset = 1;
    m_wen0 = 0; m_addr0 = 0; m_data0 = 0; m_wen1 = 0; m_addr1 = 0; m_data1 = 0;
    #2;

    step(0, 0, 3'd0, 16'h0, 0, 1);
    step(0, 0, 3'd0, 16'h0, 0, 1);
    chk("rst_waddr0", 16'(waddr0), 0);
    chk("rst_wdata0", 16'(wdata0), 0);
    chk("rst_waddr1", 16'(waddr1), 0);
    chk("rst_wdata1", 16'(wdata1), 0);
    chk("rst_in_ready", 16'(in_ready), 1);
    idle(10);

    // HL pair: H=4, L=5
    step(1, 1, 3'd2, 16'h1234, 0, 0);
    chk("hl_pend_q", 16'(pending), 8'h30);
    idle(1);
    chk("hl_wen0", 16'(wen0), 1);
    chk("hl_waddr0", 16'(waddr0), 4);
    chk("hl_wdata0", 16'(wdata0), 8'h12);
    chk("hl_wen1", 16'(wen1), 1);
    chk("hl_waddr1", 16'(waddr1), 5);
    chk("hl_wdata1", 16'(wdata1), 8'h34);
    chk("hl_pend_s", 16'(pending), 8'h30);
    idle(1);
    chk("hl_pend_clr", 16'(pending), 0);
    idle(2);

    step(1, 0, 3'd0, 16'h0011, 0, 0);
    step(1, 0, 3'd1, 16'h0022, 0, 0);
    idle(3);
    step(1, 0, 3'd7, 16'h0055, 0, 0);
    step(1, 0, 3'd7, 16'h0066, 0, 0);
    idle(3);

    // PSW pair: A=7 high, F=6 low
    step(1, 1, 3'd3, 16'hABCD, 0, 0);
    idle(1);
    chk("psw_waddr0", 16'(waddr0), 7);
    chk("psw_wdata0", 16'(wdata0), 8'hAB);
    chk("psw_waddr1", 16'(waddr1), 6);
    chk("psw_wdata1", 16'(wdata1), 8'hCD);
    idle(2);
    step(1, 0, 3'd2, 16'h0099, 0, 0);
    step(1, 1, 3'd0, 16'h7788, 0, 0);
    idle(3);

    for (int i = 0; i < 2 * DEPTH; i++)
      step(1, i[0], 3'(i), 16'($urandom), 0, 0);
    idle(3);

    step(1, 0, 3'd1, 16'h00AA, 0, 0);
    step(1, 1, 3'd1, 16'hBBCC, 0, 0);
    step(1, 0, 3'd3, 16'h00DD, 0, 0);
    step(1, 0, 3'd4, 16'h00EE, 1, 0);
    chk("flush_count", 16'(count), 0);
    chk("flush_pend", 16'(pending), 0);
    idle(2);

    step(1, 1, 3'd0, 16'h4242, 0, 0);
    step(1, 0, 3'd5, 16'h0043, 0, 0);
    step(1, 0, 3'd6, 16'h0044, 1, 1);
    chk("midrst_count", 16'(count), 0);
    chk("midrst_waddr0", 16'(waddr0), 0);
    idle(2);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom), 16'($urandom),
           $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
